perm_shuffle_ctrl: RTL and testbench

PERM_SHUFFLE_CTRL -- requirements
Module: perm_shuffle_ctrl

---
 rtl/perm_shuffle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_perm_shuffle_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_shuffle_ctrl.sv
// perm_shuffle_ctrl
// Produces a pseudo-random permutation of 0..N-1 and streams it out over a
// valid/ready handshake.
//
// A run goes through four phases:
//   IDLE    : waits for start; seed_load can reseed the LFSR here.
//   INIT    : writes array[k] = k, one entry per cycle.
//   SHUFFLE : one Fisher-Yates swap per cycle, from i = N-1 down to i = 1.
//   STREAM  : presents array[0..N-1] in order.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a new run (ignored unless IDLE)
//   seed_load  load seed into the LFSR (ignored unless IDLE); a zero seed
//              maps to 32'hACE1
//   seed       32-bit LFSR seed
//   busy       high whenever the controller is not IDLE
//   out_valid  out_data carries a permutation entry (STREAM)
//   out_ready  consumer accepts the current entry
//   out_data   permutation entry, W bits
//   out_last   current entry is the one at index N-1
//   done       single-cycle pulse after the last entry is accepted
//
// The LFSR is never reseeded by start, so consecutive runs produce
// different permutations. The swap index j is taken from the top of a 17x16
// product, which assumes N <= 65536.
module perm_shuffle_ctrl #(
  parameter int N = 16,
  localparam int W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         seed_load,
  input  logic [31:0]  seed,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    SHUFFLE = 2'd2,
    STREAM  = 2'd3
  } state_t;

  localparam logic [W-1:0] LAST_IDX     = W'(N - 1);
  localparam logic [31:0]  LFSR_DEFAULT = 32'hACE1;

  state_t       state_reg, state_next;
  logic [31:0]  lfsr_reg, lfsr_next;
  logic [W-1:0] k_reg, k_next;
  logic [W-1:0] i_reg, i_next;
  logic [W-1:0] r_reg, r_next;
  logic         done_reg, done_next;
  logic [W-1:0] array_reg [0:N-1];

  logic         init_wr;
  logic         swap_en;
  logic         lfsr_fb;
  logic [16:0]  i_plus1;
  logic [32:0]  j_prod;
  logic [W-1:0] j;
  logic         unused_prod_bits;

  assign lfsr_fb = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];

  // j = floor(lfsr[15:0] * (i+1) / 2^16) always lands in 0..i, giving an
  // unbiased-enough index without a divider.
  assign i_plus1 = 17'(i_reg) + 17'd1;
  assign j_prod  = {17'd0, lfsr_reg[15:0]} * {16'd0, i_plus1};
  assign j       = j_prod[16 +: W];
  assign unused_prod_bits = ^{j_prod[15:0], j_prod[32:16+W]};

  // Next-state and control
  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    k_next     = k_reg;
    i_next     = i_reg;
    r_next     = r_reg;
    done_next  = 1'b0;
    init_wr    = 1'b0;
    swap_en    = 1'b0;

    case (state_reg)
      IDLE: begin
        // A seed loaded together with start is already in place when
        // SHUFFLE first reads the LFSR.
        if (seed_load) begin
          lfsr_next = (seed == 32'd0) ? LFSR_DEFAULT : seed;
        end
        if (start) begin
          state_next = INIT;
          k_next     = '0;
        end
      end

      INIT: begin
        init_wr = 1'b1;
        if (k_reg == LAST_IDX) begin
          i_next     = LAST_IDX;
          r_next     = '0;
          // A single-entry permutation has nothing to swap.
          state_next = (N == 1) ? STREAM : SHUFFLE;
        end else begin
          k_next = k_reg + W'(1);
        end
      end

      SHUFFLE: begin
        swap_en   = 1'b1;
        lfsr_next = {lfsr_reg[30:0], lfsr_fb};
        i_next    = i_reg - W'(1);
        if (i_reg == W'(1)) begin
          state_next = STREAM;
          r_next     = '0;
        end
      end

      STREAM: begin
        if (out_ready) begin
          if (r_reg == LAST_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
            r_next     = '0;
          end else begin
            r_next = r_reg + W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      lfsr_reg  <= LFSR_DEFAULT;
      k_reg     <= '0;
      i_reg     <= '0;
      r_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      k_reg     <= k_next;
      i_reg     <= i_next;
      r_reg     <= r_next;
      done_reg  <= done_next;
    end
  end

  // Permutation storage. A swap writes two entries in one cycle, so this is
  // a register array rather than a RAM. When i == j both branches write the
  // same value, which is the correct no-op swap.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        array_reg[k] <= W'(k);
      end else if (init_wr && (k_reg == W'(k))) begin
        array_reg[k] <= W'(k);
      end else if (swap_en && (i_reg == W'(k))) begin
        array_reg[k] <= array_reg[j];
      end else if (swap_en && (j == W'(k))) begin
        array_reg[k] <= array_reg[i_reg];
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == STREAM);
  assign out_data  = array_reg[r_reg];
  assign out_last  = out_valid && (r_reg == LAST_IDX);
  assign done      = done_reg;

endmodule

// File: tb/tb_perm_shuffle_ctrl.sv
// tb_perm_shuffle_ctrl
// Drives three instances of perm_shuffle_ctrl (N = 16, 4 and 1) with
// randomized handshakes and control pulses, and compares every streamed
// entry against a Fisher-Yates model computed on plain integer arrays.
module tb_perm_shuffle_ctrl;

  logic clk;

  // Per-instance signals: index 0 -> N=16, 1 -> N=4, 2 -> N=1
  logic        reset_s     [3];
  logic        start_s     [3];
  logic        seed_load_s [3];
  logic [31:0] seed_s      [3];
  logic        out_ready_s [3];
  logic        busy_s      [3];
  logic        ov_s        [3];
  logic        ol_s        [3];
  logic        done_s      [3];
  logic [3:0]  od16;
  logic [1:0]  od4;
  logic [0:0]  od1;

  int          n_of   [3] = '{16, 4, 1};
  bit   [31:0] m_lfsr [3];
  int          exp_q  [$];

  int checks = 0;
  int errors = 0;

  perm_shuffle_ctrl #(.N(16)) dut16 (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .seed_load(seed_load_s[0]),
    .seed(seed_s[0]), .busy(busy_s[0]), .out_valid(ov_s[0]), .out_ready(out_ready_s[0]),
    .out_data(od16), .out_last(ol_s[0]), .done(done_s[0])
  );

  perm_shuffle_ctrl #(.N(4)) dut4 (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .seed_load(seed_load_s[1]),
    .seed(seed_s[1]), .busy(busy_s[1]), .out_valid(ov_s[1]), .out_ready(out_ready_s[1]),
    .out_data(od4), .out_last(ol_s[1]), .done(done_s[1])
  );

  perm_shuffle_ctrl #(.N(1)) dut1 (
    .clk(clk), .reset(reset_s[2]), .start(start_s[2]), .seed_load(seed_load_s[2]),
    .seed(seed_s[2]), .busy(busy_s[2]), .out_valid(ov_s[2]), .out_ready(out_ready_s[2]),
    .out_data(od1), .out_last(ol_s[2]), .done(done_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] get_od(input int d);
    case (d)
      0:       return od16;
      1:       return {2'b00, od4};
      default: return {3'b000, od1};
    endcase
  endfunction

  function automatic bit [31:0] lfsr_step(input bit [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Fisher-Yates over 0..n-1 driven by the LFSR; fills exp_q and returns
  // the LFSR value left after the run.
  function automatic bit [31:0] model_shuffle(input int n, input bit [31:0] st);
    int a [$];
    bit [31:0] s;
    longint unsigned p;
    int j, t;
    s = st;
    a = {};
    for (int k = 0; k < n; k++) a.push_back(k);
    for (int i = n - 1; i >= 1; i--) begin
      p = longint'(s[15:0]) * longint'(i + 1);
      j = int'(p / 65536);
      t = a[i];
      a[i] = a[j];
      a[j] = t;
      s = lfsr_step(s);
    end
    exp_q = a;
    return s;
  endfunction

  // Reset with every other input asserted, to show reset wins.
  task automatic reset_dut(input int d);
    reset_s[d] = 1'b1;
    start_s[d] = 1'b1;
    seed_load_s[d] = 1'b1;
    seed_s[d] = 32'hDEAD_BEEF;
    out_ready_s[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val($sformatf("rst_busy_n%0d", n_of[d]), busy_s[d], 0);
    check_val($sformatf("rst_valid_n%0d", n_of[d]), ov_s[d], 0);
    check_val($sformatf("rst_last_n%0d", n_of[d]), ol_s[d], 0);
    check_val($sformatf("rst_done_n%0d", n_of[d]), done_s[d], 0);
    reset_s[d] = 1'b0;
    start_s[d] = 1'b0;
    seed_load_s[d] = 1'b0;
    out_ready_s[d] = 1'b0;
    m_lfsr[d] = 32'hACE1;
  endtask

  task automatic load_seed(input int d, input logic [31:0] sd);
    seed_load_s[d] = 1'b1;
    seed_s[d] = sd;
    @(posedge clk);
    #1;
    seed_load_s[d] = 1'b0;
    m_lfsr[d] = (sd == 32'd0) ? 32'hACE1 : sd;
  endtask

  // One shuffle run. pct = chance (percent) of out_ready each cycle;
  // inject pulses start/seed_load randomly while busy; do_seed loads sd in
  // the same cycle as start; abort_at >= 0 asserts reset on that transfer.
  task automatic run_shuffle(input int d, input int pct, input bit inject,
                             input bit do_seed, input logic [31:0] sd, input int abort_at);
    int n, cnt, idx, guard, distinct;
    int seen [16];
    bit rdy;
    logic [3:0] val;
    n = n_of[d];

    start_s[d] = 1'b1;
    seed_load_s[d] = do_seed;
    seed_s[d] = sd;
    if (do_seed) m_lfsr[d] = (sd == 32'd0) ? 32'hACE1 : sd;
    m_lfsr[d] = model_shuffle(n, m_lfsr[d]);

    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      start_s[d] = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      seed_load_s[d] = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      seed_s[d] = $urandom;
    end while (!ov_s[d] && cnt < 200);
    check_val($sformatf("latency_n%0d", n), cnt, 2 * n);
    if (!ov_s[d]) begin
      start_s[d] = 1'b0;
      seed_load_s[d] = 1'b0;
      return;
    end

    for (int k = 0; k < 16; k++) seen[k] = 0;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 500) begin
      rdy = ($urandom_range(0, 99) < pct) || (idx == abort_at);
      out_ready_s[d] = rdy;
      if (inject) begin
        start_s[d] = 1'($urandom_range(0, 1));
        seed_load_s[d] = 1'($urandom_range(0, 1));
        seed_s[d] = $urandom;
      end
      val = get_od(d);
      check_val($sformatf("data_n%0d_idx%0d", n, idx), val, exp_q[idx]);
      check_val($sformatf("valid_n%0d", n), ov_s[d], 1);
      check_val($sformatf("last_n%0d_idx%0d", n, idx), ol_s[d], (idx == n - 1) ? 1 : 0);
      check_val($sformatf("done_early_n%0d", n), done_s[d], 0);

      if (idx == abort_at) begin
        reset_s[d] = 1'b1;
        @(posedge clk);
        #1;
        check_val($sformatf("abort_busy_n%0d", n), busy_s[d], 0);
        check_val($sformatf("abort_valid_n%0d", n), ov_s[d], 0);
        check_val($sformatf("abort_done_n%0d", n), done_s[d], 0);
        reset_s[d] = 1'b0;
        out_ready_s[d] = 1'b0;
        start_s[d] = 1'b0;
        seed_load_s[d] = 1'b0;
        @(posedge clk);
        #1;
        check_val($sformatf("abort_done2_n%0d", n), done_s[d], 0);
        check_val($sformatf("abort_busy2_n%0d", n), busy_s[d], 0);
        m_lfsr[d] = 32'hACE1;
        $display("run n=%0d aborted by reset at transfer %0d", n, idx);
        return;
      end

      @(posedge clk);
      #1;
      guard++;
      if (rdy) begin
        seen[val]++;
        idx++;
      end
    end

    out_ready_s[d] = 1'b0;
    start_s[d] = 1'b0;
    seed_load_s[d] = 1'b0;
    check_val($sformatf("xfers_n%0d", n), idx, n);
    check_val($sformatf("done_n%0d", n), done_s[d], 1);
    check_val($sformatf("idle_busy_n%0d", n), busy_s[d], 0);
    check_val($sformatf("idle_valid_n%0d", n), ov_s[d], 0);
    distinct = 0;
    for (int k = 0; k < n; k++) if (seen[k] == 1) distinct++;
    check_val($sformatf("perm_set_n%0d", n), distinct, n);
    @(posedge clk);
    #1;
    check_val($sformatf("done_pulse_n%0d", n), done_s[d], 0);
    $display("run n=%0d latency=%0d stall_cycles=%0d inject=%0d", n, cnt, guard - idx, inject);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset_s[d] = 1'b1;
      start_s[d] = 1'b0;
      seed_load_s[d] = 1'b0;
      seed_s[d] = 32'd0;
      out_ready_s[d] = 1'b0;
      m_lfsr[d] = 32'hACE1;
    end

    // N = 4: first run from the reset seed, then a stalled run
    reset_dut(1);
    run_shuffle(1, 100, 1'b0, 1'b0, 32'd0, -1);
    run_shuffle(1, 50, 1'b0, 1'b0, 32'd0, -1);

    // N = 1
    reset_dut(2);
    run_shuffle(2, 100, 1'b0, 1'b0, 32'd0, -1);
    run_shuffle(2, 40, 1'b1, 1'b0, 32'd0, -1);

    // N = 16
    reset_dut(0);
    run_shuffle(0, 100, 1'b0, 1'b0, 32'd0, -1);
    run_shuffle(0, 100, 1'b0, 1'b0, 32'd0, -1);
    load_seed(0, 32'd0);
    run_shuffle(0, 70, 1'b0, 1'b0, 32'd0, -1);
    reset_dut(0);
    load_seed(0, 32'h1234_5678);
    run_shuffle(0, 50, 1'b0, 1'b0, 32'd0, -1);
    reset_dut(0);
    load_seed(0, 32'h1234_5678);
    run_shuffle(0, 50, 1'b0, 1'b0, 32'd0, -1);
    run_shuffle(0, 60, 1'b1, 1'b0, 32'd0, -1);
    run_shuffle(0, 80, 1'b0, 1'b1, $urandom | 32'd1, -1);
    run_shuffle(0, 100, 1'b0, 1'b0, 32'd0, 2);
    run_shuffle(0, 50, 1'b0, 1'b0, 32'd0, -1);
    for (int t = 0; t < 5; t++) begin
      run_shuffle(0, $urandom_range(20, 100), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
